// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 types and divider issuer state encoding
package fpu_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic {
    IDLE,
    WAIT_RES
  } issuer_state_t;

  // Quiet NaN with the same encoding the divider produces for invalid operations
  localparam fp32_t FP32_QNAN = 32'hFFC00000;

endpackage

// File: rtl/fpu_op_fifo.sv
// rtl/fpu_op_fifo.sv - synchronous operand FIFO, registered pointers, not fall-through
module fpu_op_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  // Extra pointer MSB distinguishes a full wrap from empty
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fpu_div_issuer.sv
// rtl/fpu_div_issuer.sv - FP32 divider request front end; FPU_DIV_TIMEOUT_EN adds a watchdog
// Issues one queued operand pair at a time and holds each quotient until downstream takes it.
module fpu_div_issuer
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_din1,
  output logic [31:0]      div_din2,
  output logic             div_valid,
  input  logic [31:0]      div_result,
  input  logic             div_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             err_timeout
);

  localparam int FW = TAG_W + 64;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("fpu_div_issuer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  issuer_state_t    state_q;
  issuer_state_t    state_d;
  logic [FW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issue;
  logic             capture;
  logic             wd_fire;
  logic [TAG_W-1:0] pend_tag;

  fpu_op_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data ({in_tag, in_b, in_a}),
    .pop       (issue),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state_q == WAIT_RES);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Issue only into a free output slot so a completion always has somewhere to land
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !out_valid) begin
          issue   = 1'b1;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (div_ready) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (wd_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FPU_DIV_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (issue)                  wd_cnt <= '0;
      else if (state_q == WAIT_RES) wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire) err_q <= 1'b1;
    end
  end

  assign wd_fire     = (state_q == WAIT_RES) && !div_ready && (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign err_timeout = err_q;
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      div_valid  <= 1'b0;
      div_din1   <= '0;
      div_din2   <= '0;
      pend_tag   <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      div_valid <= issue;
      if (issue) begin
        div_din1 <= head[31:0];
        div_din2 <= head[63:32];
        pend_tag <= head[FW-1:64];
      end
      if (capture || wd_fire) begin
        out_result <= capture ? div_result : FP32_QNAN;
        out_tag    <= pend_tag;
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_div_issuer.sv
// tb/tb_fpu_div_issuer.sv - scoreboard bench for fpu_div_issuer with a randomized divider stub
module tb_fpu_div_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic [31:0] div_din1;
  logic [31:0] div_din2;
  logic        div_valid;
  logic [31:0] div_result;
  logic        div_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        busy;
  logic        err_timeout;

  int checks   = 0;
  int errors   = 0;
  int dv_count = 0;
  int ready_mode = 0;   // 0 hold low, 1 hold high, 2 random
  int stub_mode  = 0;   // 0 normal, 1 never answer, 2 answer after 300 cycles

  logic [63:0] iss_q[$];   // {b, a} expected at the divider, in order
  logic [35:0] exp_q[$];   // {tag, quotient} expected downstream, in order

  fpu_div_issuer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .div_din1    (div_din1),
    .div_din2    (div_din2),
    .div_valid   (div_valid),
    .div_result  (div_result),
    .div_ready   (div_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Reference quotient: exact for the named vectors, IEEE specials for zero divisors, a fixed mix otherwise
  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (b[30:0] == 31'd0) return (a[30:0] == 31'd0) ? 32'hFFC00000 : {a[31] ^ b[31], 8'hFF, 23'd0};
    return {a[31] ^ b[31], a[30:0] ^ {b[7:0], b[30:8]}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_in_ready"}, in_ready, 1);
    check({p, "_div_valid"}, div_valid, 0);
    check({p, "_div_din"}, {div_din2, div_din1}, 0);
    check({p, "_out_valid"}, out_valid, 0);
    check({p, "_out_result"}, out_result, 0);
    check({p, "_out_tag"}, out_tag, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_err_timeout"}, err_timeout, 0);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag, input bit nan);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = tag;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready stuck at 0 expected 1");
    end else begin
      iss_q.push_back({b, a});
      exp_q.push_back({tag, nan ? 32'hFFC00000 : fdiv(a, b)});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0 || iss_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d results pending expected 0", name, exp_q.size());
    end
  endtask

  // Divider stub
  initial begin
    logic [31:0] a, b;
    int lat;
    bit aborted;
    div_ready = 1'b0;
    div_result = '0;
    forever begin
      @(negedge clk);
      if (div_valid && !reset) begin
        a = div_din1;
        b = div_din2;
        lat = (stub_mode == 2) ? 300 : int'($urandom_range(1, 6));
        aborted = 1'b0;
        repeat (lat) begin
          @(posedge clk);
          if (reset) aborted = 1'b1;
        end
        #1;
        if (!aborted && stub_mode != 1) begin
          div_result = fdiv(a, b);
          div_ready = 1'b1;
          @(posedge clk);
          #1 div_ready = 1'b0;
        end
      end
    end
  end

  // Downstream ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: divider issue and downstream transfers against the scoreboard queues
  initial begin
    logic prev_dv = 1'b0;
    logic [63:0] e;
    logic [35:0] r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (div_valid) begin
          dv_count++;
          if (prev_dv) begin
            checks++;
            errors++;
            $display("FAIL div_valid_width: high 2 cycles expected 1");
          end
          if (iss_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_issue: got %h/%h expected none", div_din1, div_din2);
          end else begin
            e = iss_q.pop_front();
            check("issue_operands", {div_din2, div_din1}, e);
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out: got %h tag %h expected none", out_result, out_tag);
          end else begin
            r = exp_q.pop_front();
            check("out_tag_result", {out_tag, out_result}, r);
          end
        end
      end
      prev_dv = div_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int dv0;
    int n;
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals("reset");

    // Basic divide with issue latency
    ready_mode = 1;
    push(32'h40C00000, 32'h40000000, 4'd3, 1'b0);
    check("lat_n1_div_valid", div_valid, 0);
    @(posedge clk);
    #1 check("lat_n2_div_valid", div_valid, 1);
    wait_drain("basic");
    check("basic_result", out_result, 32'h40400000);
    check("basic_tag", out_tag, 3);

    // IEEE corner cases, order preserved
    push(32'h3F800000, 32'h00000000, 4'd5, 1'b0);
    push(32'h00000000, 32'h00000000, 4'd6, 1'b0);
    wait_drain("corner");
    check("corner_last_result", out_result, 32'hFFC00000);

    // Backpressure: output slot held, FIFO fills
    ready_mode = 0;
    dv0 = dv_count;
    acc = 0;
    for (int c = 0; c < 24; c++) begin
      in_valid = 1'b1;
      in_a = $urandom;
      in_b = $urandom;
      in_tag = acc[3:0];
      @(negedge clk);
      if (in_ready) begin
        iss_q.push_back({in_b, in_a});
        exp_q.push_back({in_tag, fdiv(in_a, in_b)});
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 5);
    check("bp_in_ready", in_ready, 0);
    check("bp_single_issue", dv_count - dv0, 1);
    ready_mode = 1;
    wait_drain("bp");

    // Random traffic with random backpressure; pushes overlap FSM pops
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
      push($urandom, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end
    ready_mode = 1;
    wait_drain("random");

`ifdef FPU_DIV_TIMEOUT_EN
    stub_mode = 2;
    push(32'h40C00000, 32'h40000000, 4'd9, 1'b1);
    n = 0;
    while (!div_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wd_latency", n, 255);
    check("wd_result", out_result, 32'hFFC00000);
    check("wd_err", err_timeout, 1);
    repeat (80) @(posedge clk);
    #1;
    check("wd_late_ignored", {busy, out_valid}, 0);
    check("wd_err_sticky", err_timeout, 1);
    stub_mode = 0;
    wait_drain("wd");
`endif

    // Reset during WAIT_RES with two queued requests
    stub_mode = 1;
    push($urandom, $urandom, 4'd1, 1'b0);
    push($urandom, $urandom, 4'd2, 1'b0);
    push($urandom, $urandom, 4'd4, 1'b0);
    check("mid_busy", busy, 1);
    iss_q.delete();
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals("mid_reset");
    stub_mode = 0;
    repeat (30) @(posedge clk);
    #1;
    check("post_reset_idle", {in_ready, busy, out_valid, div_valid}, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
